// File: rtl/crypto_decrypt.sv
// Stream decryptor: the header stays in clear, and payload lanes are XORed with a key latched on each packet's first beat.
// A 4-entry fallthrough FIFO feeds a single output register stage.
module crypto_decrypt #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int HDR_BYTES            = 42
) (
    input  logic                              axis_aclk,
    input  logic                              axis_resetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,

    input  logic [31:0]                       key,
    output logic [31:0]                       pkt_count
);

    localparam int          DW       = C_S_AXIS_DATA_WIDTH;
    localparam int          UW       = C_S_AXIS_TUSER_WIDTH;
    localparam int          KW       = DW / 8;
    localparam int          FIFO_W   = DW + UW + KW + 1;
    localparam int unsigned LANES    = KW;
    localparam int unsigned HDR_LANE = HDR_BYTES - KW;

    typedef enum logic [1:0] {BEAT0, BEAT1, PAYLOAD} state_t;

    state_t              state;
    logic [31:0]         key_lat;

    logic [FIFO_W-1:0]   mem [4];
    logic [1:0]          wr_ptr;
    logic [1:0]          rd_ptr;
    logic [2:0]          depth;
    logic                fifo_empty;
    logic                nearly_full;
    logic                wr_en;
    logic                rd_en;

    logic [DW-1:0]       f_data;
    logic [UW-1:0]       f_user;
    logic [KW-1:0]       f_keep;
    logic                f_last;
    logic [DW-1:0]       dec_data;

    assign fifo_empty    = (depth == 3'd0);
    assign nearly_full   = (depth >= 3'd3);
    // Gated by reset so no handshake can complete while the block is held in reset.
    assign s_axis_tready = !nearly_full && axis_resetn;
    assign wr_en         = s_axis_tvalid && s_axis_tready;
    assign rd_en         = !fifo_empty && (!m_axis_tvalid || m_axis_tready);

    assign {f_data, f_user, f_keep, f_last} = mem[rd_ptr];

    always_ff @(posedge axis_aclk) begin
        if (wr_en)
            mem[wr_ptr] <= {s_axis_tdata, s_axis_tuser, s_axis_tkeep, s_axis_tlast};
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            depth  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 2'd1;
            if (rd_en)
                rd_ptr <= rd_ptr + 2'd1;
            depth <= depth + {2'b00, wr_en} - {2'b00, rd_en};
        end
    end

    // The first beat is always clear; the second beat is clear up to the end of the header.
    always_comb begin
        dec_data = f_data;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (f_keep[i] && (state == PAYLOAD || (state == BEAT1 && i >= HDR_LANE)))
                dec_data[8*i +: 8] = f_data[8*i +: 8] ^ key_lat[8*(i%4) +: 8];
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state   <= BEAT0;
            key_lat <= '0;
        end else if (rd_en) begin
            if (state == BEAT0)
                key_lat <= key;
            if (f_last)
                state <= BEAT0;
            else if (state == BEAT0)
                state <= BEAT1;
            else
                state <= PAYLOAD;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else if (rd_en) begin
            m_axis_tdata  <= dec_data;
            m_axis_tkeep  <= f_keep;
            m_axis_tuser  <= f_user;
            m_axis_tlast  <= f_last;
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn)
            pkt_count <= '0;
        else if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
            pkt_count <= pkt_count + 32'd1;
    end

endmodule

// File: tb/tb_crypto_decrypt.sv
// Directed bench for crypto_decrypt: hand-computed expected beats, checked with immediate assertions.
module tb_crypto_decrypt;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [255:0]  s_tdata;
    logic [31:0]   s_tkeep;
    logic [127:0]  s_tuser;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tready;
    logic [255:0]  m_tdata;
    logic [31:0]   m_tkeep;
    logic [127:0]  m_tuser;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready;
    logic [31:0]   key;
    logic [31:0]   pkt_count;

    always #5 clk = ~clk;

    crypto_decrypt #(
        .C_M_AXIS_DATA_WIDTH (256),
        .C_S_AXIS_DATA_WIDTH (256),
        .C_M_AXIS_TUSER_WIDTH(128),
        .C_S_AXIS_TUSER_WIDTH(128),
        .HDR_BYTES           (42)
    ) dut (
        .axis_aclk    (clk),
        .axis_resetn  (rstn),
        .s_axis_tdata (s_tdata),
        .s_axis_tkeep (s_tkeep),
        .s_axis_tuser (s_tuser),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tlast (s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tkeep (m_tkeep),
        .m_axis_tuser (m_tuser),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tlast (m_tlast),
        .m_axis_tready(m_tready),
        .key          (key),
        .pkt_count    (pkt_count)
    );

    typedef struct {
        logic [255:0] d;
        logic [31:0]  k;
        logic [127:0] u;
        logic         l;
    } beat_t;

    localparam logic [255:0] ZERO   = '0;
    localparam logic [127:0] USER   = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [255:0] B1_A5  = {{22{8'hA5}}, {10{8'h00}}};
    localparam logic [255:0] ALL_A5 = {32{8'hA5}};
    localparam logic [255:0] FILL11 = {32{8'h11}};
    localparam logic [255:0] B2_KM  = {{28{8'h11}}, 8'h15, 8'h12, 8'h13, 8'h10};
    localparam logic [255:0] B1_K1  = {{5{32'h00000001}}, 96'h0};
    localparam logic [255:0] B2_K1  = {8{32'h00000001}};
    localparam logic [255:0] B1_K2  = {{5{32'h00000002}}, 96'h0};
    localparam logic [255:0] FILL5A = {32{8'h5A}};

    beat_t       q[$];
    int unsigned s_acc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    always @(posedge clk) begin
        if (m_tvalid && m_tready)
            q.push_back('{m_tdata, m_tkeep, m_tuser, m_tlast});
        if (s_tvalid && s_tready)
            s_acc++;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [255:0] d, input logic [31:0] k, input logic [127:0] u, input logic l);
        int unsigned start;
        int unsigned n;
        start    = s_acc;
        n        = 0;
        s_tdata  = d;
        s_tkeep  = k;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = 1'b1;
        while (s_acc == start && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        s_tvalid = 1'b0;
        chk32("send_accept", s_acc - start, 32'd1);
    endtask

    task automatic wait_out(input int unsigned n, input string tag);
        int unsigned c;
        c = 0;
        while (q.size() < n && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk32(tag, 32'(q.size() >= n), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] held;
        logic [7:0]   b;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tuser  = '0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        key      = 32'hA5A5A5A5;

        // Reset state
        repeat (3) @(negedge clk);
        chk32("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk32("rst_tlast", 32'(m_tlast), 32'd0);
        chk("rst_tdata", m_tdata, ZERO);
        chk32("rst_count", pkt_count, 32'd0);
        chk32("rst_s_tready", 32'(s_tready), 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk32("s_tready_after_rst", 32'(s_tready), 32'd1);

        // 3-beat packet, key A5A5A5A5, plus first-beat latency
        send(ZERO, '1, USER, 1'b0);
        @(negedge clk);
        chk32("latency_edge_n", 32'(m_tvalid), 32'd0);
        @(negedge clk);
        chk32("latency_edge_n1", 32'(m_tvalid), 32'd1);
        chk("latency_data", m_tdata, ZERO);
        send(ZERO, '1, USER, 1'b0);
        send(ZERO, '1, USER, 1'b1);
        wait_out(3, "a5_wait");
        chk("a5_beat0", q[0].d, ZERO);
        chk("a5_beat1", q[1].d, B1_A5);
        chk("a5_beat2", q[2].d, ALL_A5);
        chk("a5_user", {128'h0, q[2].u}, {128'h0, USER});
        chk32("a5_last", 32'(q[2].l), 32'd1);
        chk32("a5_count", pkt_count, 32'd1);
        q.delete();

        // Partial tkeep on payload beat
        key = 32'h04030201;
        send(FILL11, '1, USER, 1'b0);
        send(FILL11, '1, USER, 1'b0);
        send(FILL11, 32'h0000000F, USER, 1'b1);
        wait_out(3, "keep_wait");
        chk("keep_beat0", q[0].d, FILL11);
        chk("keep_beat2", q[2].d, B2_KM);
        chk32("keep_tkeep", q[2].k, 32'h0000000F);
        chk32("keep_count", pkt_count, 32'd2);
        q.delete();

        // Key change mid-packet, then a two-beat packet with the new key
        key = 32'h00000001;
        send(ZERO, '1, USER, 1'b0);
        send(ZERO, '1, USER, 1'b0);
        key = 32'h00000002;
        send(ZERO, '1, USER, 1'b1);
        wait_out(3, "keychg_wait");
        chk("keychg_beat1", q[1].d, B1_K1);
        chk("keychg_beat2", q[2].d, B2_K1);
        q.delete();
        send(ZERO, '1, USER, 1'b0);
        send(ZERO, '1, USER, 1'b1);
        wait_out(2, "two_beat_wait");
        chk("two_beat_b0", q[0].d, ZERO);
        chk("two_beat_b1", q[1].d, B1_K2);
        chk32("two_beat_last", 32'(q[1].l), 32'd1);
        chk32("two_beat_count", pkt_count, 32'd4);
        q.delete();

        // Back-to-back single-beat packets stay in clear
        for (int i = 0; i < 3; i++)
            send(FILL5A, '1, USER, 1'b1);
        wait_out(3, "single_wait");
        for (int i = 0; i < 3; i++)
            chk("single_data", q[i].d, FILL5A);
        chk32("single_count", pkt_count, 32'd7);
        q.delete();

        // Counter wrap
        @(negedge clk);
        force dut.pkt_count = 32'hFFFFFFFF;
        #1 release dut.pkt_count;
        chk32("wrap_preload", pkt_count, 32'hFFFFFFFF);
        send(FILL5A, '1, USER, 1'b1);
        wait_out(1, "wrap_wait");
        chk32("wrap_count", pkt_count, 32'd0);
        q.delete();

        // Output stall with 8 back-to-back beats
        key = 32'h00000000;
        m_tready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send({32{8'(8'h80 + i)}}, '1, USER, (i == 7));
            end
            begin
                repeat (3) @(negedge clk);
                held = m_tdata;
                chk("stall_first", held, {32{8'h80}});
                for (int c = 0; c < 7; c++) begin
                    @(negedge clk);
                    chk("stall_hold", m_tdata, {32{8'h80}});
                end
                chk32("stall_tvalid", 32'(m_tvalid), 32'd1);
                chk32("stall_s_tready", 32'(s_tready), 32'd0);
                m_tready = 1'b1;
            end
        join
        wait_out(8, "stall_wait");
        for (int i = 0; i < 8; i++) begin
            b = 8'h80 + 8'(i);
            chk("stall_order", q[i].d, {32{b}});
        end
        chk32("stall_last", 32'(q[7].l), 32'd1);
        chk32("stall_count", pkt_count, 32'd1);
        q.delete();

        // Reset during the second beat of a 4-beat packet
        key = 32'hA5A5A5A5;
        send(ZERO, '1, USER, 1'b0);
        send(ZERO, '1, USER, 1'b0);
        chk32("pre_rst_tvalid", 32'(m_tvalid), 32'd1);
        #3 rstn = 1'b0;
        #1;
        chk32("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
        chk32("mid_rst_count", pkt_count, 32'd0);
        chk32("mid_rst_s_tready", 32'(s_tready), 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;
        q.delete();
        send(ZERO, '1, USER, 1'b0);
        send(ZERO, '1, USER, 1'b1);
        wait_out(2, "post_rst_wait");
        chk("post_rst_beat0", q[0].d, ZERO);
        chk("post_rst_beat1", q[1].d, B1_A5);
        chk32("post_rst_count", pkt_count, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
